// File: rtl/mem_readback_scanner.sv
// Sweeps an inclusive BRAM address window and streams every word on a valid/ready port,
// keeping a word count, a popcount and a rotate-XOR signature of everything delivered.
module mem_readback_scanner #(
    parameter int WID_MEM   = 1,
    parameter int DEPTH_MEM = 32768,
    parameter int RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        start_addr,
    input  logic [31:0]        end_addr,
    output logic [31:0]        raddr,
    input  logic [WID_MEM-1:0] rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WID_MEM-1:0] out_data,
    output logic [31:0]        out_addr,
    output logic               busy,
    output logic               done,
    output logic [31:0]        word_count,
    output logic [31:0]        ones_count,
    output logic [31:0]        signature
);

    localparam int          FIFO_DEPTH = RD_LAT + 2;
    localparam int          PW         = $clog2(FIFO_DEPTH);
    localparam int          CW         = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
    localparam int          NSLICE     = (WID_MEM + 31) / 32;
    localparam logic [31:0] MAX_ADDR   = 32'(DEPTH_MEM - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    function automatic logic [31:0] popcount(input logic [WID_MEM-1:0] d);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < WID_MEM; i++) c = c + 32'(d[i]);
        return c;
    endfunction

    function automatic logic [31:0] fold32(input logic [WID_MEM-1:0] d);
        logic [NSLICE*32-1:0] ext;
        logic [31:0]          f;
        ext = '0;
        ext[WID_MEM-1:0] = d;
        f = '0;
        for (int i = 0; i < NSLICE; i++) f = f ^ ext[i*32 +: 32];
        return f;
    endfunction

    // Reset asserts asynchronously but is released on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    state_t                state, next_state;
    logic [31:0]           next_addr, last_addr, end_clamped;
    logic                  start_ok, issue, push, pop;
    logic [RD_LAT:0]       tag_valid;
    logic [31:0]           tag_addr [RD_LAT+1];
    logic [CW-1:0]         inflight, fifo_count;
    logic [WID_MEM-1:0]    fifo_data [FIFO_DEPTH];
    logic [31:0]           fifo_addr [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;

    assign end_clamped = (end_addr > MAX_ADDR) ? MAX_ADDR : end_addr;
    assign start_ok    = start && ((state == IDLE) || (state == DONE));
    assign push        = tag_valid[RD_LAT];
    assign out_valid   = (fifo_count != '0);
    assign out_data    = fifo_data[rd_ptr];
    assign out_addr    = fifo_addr[rd_ptr];
    assign pop         = out_valid && out_ready;
    assign busy        = (state == SCAN) || (state == DRAIN);
    assign done        = (state == DONE);

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) inflight = inflight + CW'(tag_valid[i]);
    end

    // A word popped this cycle frees its slot, so it counts toward the reservation;
    // this keeps one issue per clock when downstream is always ready.
    assign issue = (state == SCAN) &&
                   ((fifo_count + inflight) < (CW'(FIFO_DEPTH) + CW'(pop)));

    // NOTE: every sequential block updates state with <= so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets its default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) next_state = (end_clamped < start_addr) ? DONE : SCAN;
            end
            SCAN: begin
                if (issue && (next_addr == last_addr)) next_state = DRAIN;
            end
            DRAIN: begin
                if ((inflight == '0) && (fifo_count == '0)) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr      <= '0;
            next_addr  <= '0;
            last_addr  <= '0;
            word_count <= '0;
            ones_count <= '0;
            signature  <= '0;
        end else begin
            if (start_ok) begin
                next_addr  <= start_addr;
                last_addr  <= end_clamped;
                word_count <= '0;
                ones_count <= '0;
                signature  <= '0;
            end else if (pop) begin
                word_count <= word_count + 32'd1;
                ones_count <= ones_count + popcount(out_data);
                signature  <= {signature[30:0], signature[31]} ^ fold32(out_data);
            end
            if (issue) begin
                raddr     <= next_addr;
                next_addr <= next_addr + 32'd1;
            end
        end
    end

    // Tag pipe: stage k holds the address issued k+1 clocks ago; the last stage lines up with rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            for (int i = 0; i <= RD_LAT; i++) tag_addr[i] <= '0;
        end else begin
            tag_valid[0] <= issue;
            tag_addr[0]  <= next_addr;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_addr[i]  <= tag_addr[i-1];
            end
        end
    end

    // NOTE: the FIFO storage is only a few registers and out_data/out_addr must read 0
    // after reset, so it is reset like ordinary flops rather than left as a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rdata;
                fifo_addr[wr_ptr] <= tag_addr[RD_LAT];
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
